// File: rtl/demux_1_4_stream_if.sv
// Purpose : Handshake bundle for the registered 1:4 stream demultiplexer.
//           The producer side and the four consumer ready lines are grouped here.
// Modports: master - environment side (drives d/sel/in_valid/out_ready)
//           slave  - demux side (drives in_ready/y0..y3/out_valid)
// Signals : d[W], sel[2], in_valid, in_ready, y0..y3[W], out_valid[4], out_ready[4]
interface demux_1_4_stream_if #(
  parameter int W = 4
);
  logic [W-1:0] d;
  logic [1:0]   sel;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] y0;
  logic [W-1:0] y1;
  logic [W-1:0] y2;
  logic [W-1:0] y3;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;

  modport master (
    output d, sel, in_valid, out_ready,
    input  in_ready, y0, y1, y2, y3, out_valid
  );

  modport slave (
    input  d, sel, in_valid, out_ready,
    output in_ready, y0, y1, y2, y3, out_valid
  );
endinterface

// File: rtl/demux_1_4_stream.sv
// Purpose : Registered 1:4 stream demultiplexer. One W-bit item per accept is
//           routed to one of four channels, each with a one-entry holding
//           register and its own valid/ready handshake.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset, clears all channels
//           bus   - demux_1_4_stream_if.slave (d, sel, in_valid, in_ready,
//                   y0..y3, out_valid, out_ready)
// Option  : DEMUX_1_4_STREAM_RR_EN - when defined, sel is ignored and the
//           destination comes from a 2-bit round-robin pointer that advances
//           on every accept. Undefined (default): destination is sel.
//
// Channel state machine (one per output channel)
//   state | meaning
//   EMPTY | holding register has no item, out_valid[i]=0
//   FULL  | holding register has an item, out_valid[i]=1, y_i stable until drain
module demux_1_4_stream #(
  parameter int W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  demux_1_4_stream_if.slave  bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_t;

  ch_state_t    state_q [4];
  ch_state_t    state_d [4];
  logic [W-1:0] y_q     [4];

  logic [1:0] dst;
  logic [3:0] out_valid;
  logic [3:0] acc_vec;
  logic [3:0] drain_vec;
  logic       in_ready;
  logic       accept;

`ifdef DEMUX_1_4_STREAM_RR_EN
  logic [1:0] ptr_q;

  // Pointer only moves on a real accept, so a stalled channel keeps it parked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 2'd0;
    end else if (accept) begin
      ptr_q <= ptr_q + 2'd1;
    end
  end

  assign dst = ptr_q;
`else
  assign dst = bus.sel;
`endif

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      out_valid[i] = (state_q[i] == FULL);
    end
  end

  // A full channel can still take a new item when its consumer drains the old
  // one in the same cycle; in_valid deliberately does not feed in_ready.
  assign in_ready  = ~out_valid[dst] | bus.out_ready[dst];
  assign accept    = bus.in_valid & in_ready;
  assign acc_vec   = accept ? (4'b0001 << dst) : 4'b0000;
  assign drain_vec = out_valid & bus.out_ready;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        EMPTY: begin
          if (acc_vec[i]) begin
            state_d[i] = FULL;
          end
        end
        FULL: begin
          if (drain_vec[i] && !acc_vec[i]) begin
            state_d[i] = EMPTY;
          end
        end
        default: state_d[i] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= EMPTY;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  // y_i keeps its last value after a drain; only an accept to channel i loads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        y_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (acc_vec[i]) begin
          y_q[i] <= bus.d;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.y0        = y_q[0];
  assign bus.y1        = y_q[1];
  assign bus.y2        = y_q[2];
  assign bus.y3        = y_q[3];

endmodule
